// File: rtl/priority_event_queue.sv
// priority_event_queue
//   Collects per-line event strobes into a pending set and serves them one at
//   a time through a single-entry valid/ready output register.
//   Default arbitration is fixed priority (bit 0 highest). Defining the macro
//   PRIO_ROTATE_EN compiles in round-robin arbitration with a rotate pointer.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_in     [WIDTH-1:0] event strobes, ORed into pending every clock
//   out_ready  consumer accepts out_pos when high
//   out_valid  out_pos holds a served request
//   out_pos    [POS_W-1:0] binary index of the served line
//   pending    [WIDTH-1:0] registered set of requests not yet served
//   coalesce   one-cycle pulse when a strobe merged into an already-pending bit
module priority_event_queue #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] out_pos,
  output logic [WIDTH-1:0]         pending,
  output logic                     coalesce
);

  localparam int unsigned POS_W = $clog2(WIDTH);

  logic             out_free;
  logic             load;
  logic [POS_W-1:0] win;
  logic [WIDTH-1:0] load_mask;

  // Output register can take a new entry when empty or being consumed now.
  assign out_free  = !out_valid || out_ready;
  assign load      = out_free && (|pending);
  assign load_mask = load ? (WIDTH'(1) << win) : '0;

`ifdef PRIO_ROTATE_EN
  logic [POS_W-1:0] ptr;
  logic [WIDTH-1:0] rot;
  logic [POS_W-1:0] ofs;
  logic [POS_W:0]   sum;

  // Rotate pending so that bit ptr lands at position 0, pick the lowest set
  // bit of the rotated vector, then translate the offset back modulo WIDTH.
  always_comb begin
    logic found;
    rot   = WIDTH'({pending, pending} >> ptr);
    ofs   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && rot[i]) begin
        ofs   = POS_W'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, ofs};
    if (sum >= (POS_W+1)'(WIDTH)) begin
      sum = sum - (POS_W+1)'(WIDTH);
    end
    win = sum[POS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= (win == POS_W'(WIDTH-1)) ? '0 : win + POS_W'(1);
    end
  end
`else
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && pending[i]) begin
        win   = POS_W'(i);
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_pos   <= '0;
      coalesce  <= 1'b0;
    end else begin
      // A strobe on the bit being loaded re-arms it as a fresh event.
      pending  <= (pending & ~load_mask) | req_in;
      coalesce <= |(req_in & pending & ~load_mask);
      if (out_free) begin
        out_valid <= load;
        if (load) begin
          out_pos <= win;
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_event_queue.sv
// tb_priority_event_queue
//   Randomised and directed stimulus against a behavioural reference model of
//   the event queue (WIDTH=8). Served indices go into a scoreboard queue that
//   a negedge monitor drains on every accepted output.
module tb_priority_event_queue;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] req_in;
  logic         out_ready;
  logic         out_valid;
  logic [2:0]   out_pos;
  logic [W-1:0] pending;
  logic         coalesce;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit [W-1:0] m_pend  = '0;
  bit         m_valid = 1'b0;
  int         m_pos   = 0;
  int         m_ptr   = 0;
  bit         m_coal  = 1'b0;
  int         exp_q[$];

  priority_event_queue #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pos   (out_pos),
    .pending   (pending),
    .coalesce  (coalesce)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Search the pending set from 'start' upward with wrap-around.
  function automatic int pick(input bit [W-1:0] p, input int start);
    for (int i = 0; i < W; i++) begin
      int j;
      j = (start + i) % W;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit [W-1:0] r, input bit rdy, input bit rs);
    int k;
    if (!rs) begin
      m_pend = '0; m_valid = 0; m_pos = 0; m_ptr = 0; m_coal = 0;
      exp_q.delete();
      return;
    end
    k = -1;
    if (!m_valid || rdy) begin
`ifdef PRIO_ROTATE_EN
      k = pick(m_pend, m_ptr);
`else
      k = pick(m_pend, 0);
`endif
      m_valid = (k >= 0);
      if (k >= 0) begin
        m_pos = k;
        m_ptr = (k + 1) % W;
        exp_q.push_back(k);
        m_pend[k] = 1'b0;
      end
    end
    // coalesce looks at the pre-edge pending minus the bit being served
    m_coal = |(r & m_pend);
    m_pend = m_pend | r;
  endtask

  task automatic step(input bit [W-1:0] r, input bit rdy, input bit rs);
    req_in = r; out_ready = rdy; rst_n = rs;
    model_edge(r, rdy, rs);
    @(posedge clk);
    #1;
    chk("pending",   64'(pending),   64'(m_pend));
    chk("coalesce",  64'(coalesce),  64'(m_coal));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_pos",   64'(out_pos),   64'(m_pos));
  endtask

  // Scoreboard monitor: every accepted output must match the next served index.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_accept", 64'(out_pos), 64'hFFFF);
      end else begin
        chk("sb_accept_pos", 64'(out_pos), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    req_in = '0; out_ready = 1'b0; rst_n = 1'b0;

    // reset with all strobes high
    repeat (2) step(8'hFF, 1'b1, 1'b0);

    // single request on the top line
    step(8'h80, 1'b1, 1'b1);
    repeat (3) step(8'h00, 1'b1, 1'b1);

    // back-to-back: two lines in one strobe
    step(8'h81, 1'b1, 1'b1);
    repeat (3) step(8'h00, 1'b1, 1'b1);

    // backpressure
    step(8'h0C, 1'b0, 1'b1);
    repeat (5) step(8'h00, 1'b0, 1'b1);
    repeat (3) step(8'h00, 1'b1, 1'b1);

    // coalescing while output holds index 0
    step(8'h01, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b1);
    repeat (2) step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    repeat (4) step(8'h00, 1'b1, 1'b1);

    // strobe on the bit being loaded the same edge
    step(8'h10, 1'b1, 1'b1);
    step(8'h10, 1'b1, 1'b1);
    repeat (3) step(8'h00, 1'b1, 1'b1);

    // starvation / rotation
    repeat (8) step(8'h81, 1'b1, 1'b1);
    repeat (4) step(8'h00, 1'b1, 1'b1);

    // reset mid-operation with an unaccepted output and pending work
    repeat (2) step(8'hFF, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    step(8'h24, 1'b1, 1'b1);
    repeat (4) step(8'h00, 1'b1, 1'b1);

    // randomised traffic
    for (int c = 0; c < 1500; c++) begin
      bit [W-1:0] r;
      bit         rdy;
      bit         rs;
      r   = W'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 99) != 0);
      step(r, rdy, rs);
    end

    // drain everything and confirm nothing is left outstanding
    repeat (12) step(8'h00, 1'b1, 1'b1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/priority_event_queue.md
PRIORITY_EVENT_QUEUE -- requirements
Module: priority_event_queue

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of request lines (legal range 2..64).
REQ-002 SHALL provide localparam POS_W, value $clog2(WIDTH), width of the encoded position.
REQ-003 SHALL provide port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port req_in  input  WIDTH  per-line event strobes, sampled every clock.
REQ-006 SHALL provide port out_ready  input  1  consumer accepts out_pos when high.
REQ-007 SHALL provide port out_valid  output  1  out_pos holds a served request.
REQ-008 SHALL provide port out_pos  output  POS_W  binary index of the served line.
REQ-009 SHALL provide port pending  output  WIDTH  registered set of requests not yet served.
REQ-010 SHALL provide port coalesce  output  1  one-cycle pulse: a request merged into an already-pending bit.

Function
REQ-011 SHALL OR req_in into the pending register each cycle; req_in at edge N SHALL appear in pending after edge N.
REQ-012 SHALL hold a single-entry output register (out_valid, out_pos) and treat it as free when out_valid=0 or out_valid&out_ready.
REQ-013 SHALL, when the output register is free and pending!=0, load the winning index into out_pos, set out_valid=1 and clear that bit in pending on the same edge.
REQ-014 SHALL select the winner from the registered pending value only; req_in of the same cycle SHALL NOT participate.
REQ-015 SHALL, in fixed mode, select the lowest-index set bit (bit 0 highest priority).
REQ-016 SHALL, when the output register is free and pending=0, clear out_valid.
REQ-017 SHALL give minimum latency of 2 clocks from req_in edge to out_valid=1 and sustain one accept per clock with out_ready held high.
REQ-018 SHALL keep out_pos and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, when req_in sets a bit on the same edge that bit is loaded into the output, leave the bit set in pending (new event preserved) with coalesce=0.
REQ-020 SHALL pulse coalesce for one cycle when any req_in bit is high while the same pending bit is set and not being loaded that edge; the events merge into one.
REQ-021 SHALL never produce out_pos >= WIDTH.

Reset
REQ-022 SHALL, on an edge with rst_n=0, clear pending, out_valid, out_pos, coalesce and the rotate pointer to 0, ignoring req_in and out_ready.
REQ-023 SHALL discard an unaccepted output and all pending requests when reset asserts mid-operation; the first edge after release SHALL sample req_in normally.

Configuration
REQ-024 SHALL compile round-robin arbitration in when macro PRIO_ROTATE_EN is defined.
REQ-025 SHALL, with PRIO_ROTATE_EN, keep a POS_W-bit pointer ptr (reset 0), search pending upward from ptr wrapping at WIDTH-1 to 0, and set ptr=(k+1) mod WIDTH after loading index k.
REQ-026 SHALL, without PRIO_ROTATE_EN, use fixed priority per REQ-015 and contain no pointer register.

Verification (WIDTH=8)
REQ-027 SHALL cover reset: rst_n=0 for 2 cycles with req_in=0xFF -> pending=0x00, out_valid=0, out_pos=0, coalesce=0 throughout.
REQ-028 SHALL cover single request: req_in=0x80 for one cycle at edge N, out_ready=1 -> out_valid=1, out_pos=7 after edge N+1; out_valid=0 after edge N+2; pending=0x00.
REQ-029 SHALL cover back-to-back: req_in=0x81 one cycle, out_ready=1 -> out_pos=0 then out_pos=7 on consecutive cycles, then out_valid=0.
REQ-030 SHALL cover backpressure: req_in=0x0C one cycle, out_ready=0 for 5 cycles -> out_pos=2 stable, pending=0x08; out_ready=1 -> out_pos=3 next cycle.
REQ-031 SHALL cover coalescing: out_ready=0 with output holding pos 0, req_in=0x08 pulsed at two edges 3 cycles apart -> coalesce=1 for one cycle after the second, pending=0x08, exactly one out_pos=3 after out_ready=1.
REQ-032 SHALL cover starvation/rotation: req_in=0x81 every cycle, out_ready=1 -> without PRIO_ROTATE_EN out_pos=0 every cycle; with PRIO_ROTATE_EN out_pos alternates 0,7,0,7.
